// File: rtl/tt_um_uart_tx.sv
// rtl/tt_um_uart_tx.sv - Tiny Tapeout UART transmitter tile with byte FIFO
//
// Serialises bytes loaded from ui_in into UART frames on uo_out[0].
// Optional feature macro: TT_UART_TX_PARITY_EN (adds a parity bit, 8E1/8O1).
//
// Ports:
//   clk      tile clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      tile enable; gates writes and new frames
//   ui_in    byte to transmit, captured two clocks after the strobe is sampled
//   uo_out   [0] tx, [1] busy, [2] fifo_full, [3] fifo_empty, [4] overflow, [7:5] 0
//   uio_in   [0] write strobe (asynchronous), [1] odd-parity select
//   uio_out  constant 0
//   uio_oe   constant 0 (all uio pins are inputs)

module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_C     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Strobe synchroniser and edge detector
  logic r_sync1, r_sync2, r_prev;

  // FIFO
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_ovf;

  // Transmit engine
  state_t      r_state;
  logic        r_tx;
  logic [CW-1:0] r_baud;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;

  logic w_wr_ev, w_full, w_empty, w_bit_end, w_pop, w_wr, w_busy;
  logic w_unused;

  assign w_wr_ev   = r_sync2 & ~r_prev & ena;
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_bit_end = (r_baud == '0);
  // A pop happens when the engine can start a frame: from IDLE, or at the last
  // cycle of STOP so consecutive frames abut with no idle gap.
  assign w_pop     = ena & ~w_empty &
                     ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
  // A simultaneous pop frees a slot, so a write into a full FIFO still lands.
  assign w_wr      = w_wr_ev & (~w_full | w_pop);
  assign w_busy    = (r_state != S_IDLE) | ~w_empty;

  assign uo_out  = {3'b000, r_ovf, w_empty, w_full, w_busy, r_tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
  assign w_unused = &{1'b0, uio_in[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= uio_in[0];
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= ui_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr_ev & w_full & ~w_pop) r_ovf <= 1'b1;
    end
  end

`ifdef TT_UART_TX_PARITY_EN
  logic r_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_baud    <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
`ifdef TT_UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state   <= S_START;
      r_tx      <= 1'b0;
      r_baud    <= BAUD_RELOAD;
      r_shift   <= r_mem[r_rd_ptr];
`ifdef TT_UART_TX_PARITY_EN
      // Parity mode is latched per byte at pop time.
      r_par     <= (^r_mem[r_rd_ptr]) ^ uio_in[1];
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_baud    <= BAUD_RELOAD;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
`ifdef TT_UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
`ifdef TT_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_baud  <= BAUD_RELOAD;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Reaching here with the bit ended means no pop was possible.
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// tb/tb_tt_um_uart_tx.sv - directed self-checking bench for tt_um_uart_tx

module tb_tt_um_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       strobe = 1'b0;
  logic       odd = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int errors = 0;
  int checks = 0;

  assign uio_in = {6'b000000, odd, strobe};

  tt_um_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line[0] is the first bit on the wire
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ui_in  = b;
    strobe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (uo_out[0] == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  // Called at the first sample of a start bit; samples mid-bit.
  task automatic capture(output logic [10:0] v, input int nbits);
    v = '0;
    tick(2);
    v[0] = uo_out[0];
    for (int k = 1; k < nbits; k++) begin
      tick(CPB);
      v[k] = uo_out[0];
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      tick(1);
      if (uo_out[0] == 1'b0) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  task automatic wait_not_busy(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (uo_out[1] == 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] v;
    logic [7:0]  ob [5];

    vecs[0] = '{data: 8'hA5, line: 10'b1101001010};
    vecs[1] = '{data: 8'h00, line: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, line: 10'b1111111110};
    vecs[3] = '{data: 8'h55, line: 10'b1010101010};
    vecs[4] = '{data: 8'h3C, line: 10'b1001111000};
    vecs[5] = '{data: 8'h81, line: 10'b1100000010};
    ob[0] = 8'h11; ob[1] = 8'h22; ob[2] = 8'h33; ob[3] = 8'h44; ob[4] = 8'h55;

    rst_n = 1'b0;
    tick(2);
    chk("reset_uo_out", 32'(uo_out), 32'h09);
    chk("reset_uio_oe", 32'(uio_oe), 32'h00);
    chk("reset_uio_out", 32'(uio_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

`ifdef TT_UART_TX_PARITY_EN
    for (int p = 0; p < 2; p++) begin
      odd = p[0];
      send(8'h07);
      tick(1);
      chk("par_start", 32'(uo_out[0]), 32'd0);
      capture(v, 11);
      chk("par_data", 32'(v[8:1]), 32'h07);
      chk("par_bit", 32'(v[9]), (p == 0) ? 32'd1 : 32'd0);
      chk("par_stop", 32'(v[10]), 32'd1);
      tick(1);
      chk("par_busy_43", 32'(uo_out[1]), 32'd1);
      tick(1);
      chk("par_busy_44", 32'(uo_out[1]), 32'd0);
      tick(3);
    end
`else
    // Single byte: exact latency, bit pattern and frame length
    @(negedge clk);
    ui_in  = 8'hA5;
    strobe = 1'b1;
    tick(1);
    tick(1);
    @(negedge clk);
    strobe = 1'b0;
    tick(1);
    chk("lat_e2_tx", 32'(uo_out[0]), 32'd1);
    chk("lat_e2_not_empty", 32'(uo_out[3]), 32'd0);
    tick(1);
    chk("lat_e3_tx", 32'(uo_out[0]), 32'd0);
    chk("lat_e3_busy", 32'(uo_out[1]), 32'd1);
    capture(v, 10);
    chk("single_a5", 32'(v[9:0]), 32'(10'b1101001010));
    tick(1);
    chk("busy_at_39", 32'(uo_out[1]), 32'd1);
    tick(1);
    chk("busy_at_40", 32'(uo_out[1]), 32'd0);
    chk("empty_at_40", 32'(uo_out[3]), 32'd1);
    tick(3);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      wait_start($sformatf("tbl%0d_start", i));
      capture(v, 10);
      chk($sformatf("tbl%0d_frame", i), 32'(v[9:0]), 32'(vecs[i].line));
      wait_not_busy($sformatf("tbl%0d_idle", i));
      tick(3);
    end

    // Back-to-back frames
    send(8'h00);
    tick(1);
    chk("b2b_start0", 32'(uo_out[0]), 32'd0);
    fork
      begin
        send(8'hFF);
        send(8'h55);
      end
    join_none
    capture(v, 10);
    chk("b2b_frame0", 32'(v[9:0]), 32'(10'b1000000000));
    tick(2);
    chk("b2b_gap1", 32'(uo_out[0]), 32'd0);
    chk("b2b_not_empty", 32'(uo_out[3]), 32'd0);
    capture(v, 10);
    chk("b2b_frame1", 32'(v[9:0]), 32'(10'b1111111110));
    tick(2);
    chk("b2b_gap2", 32'(uo_out[0]), 32'd0);
    chk("b2b_empty_after_third", 32'(uo_out[3]), 32'd1);
    capture(v, 10);
    chk("b2b_frame2", 32'(v[9:0]), 32'(10'b1010101010));
    wait_not_busy("b2b_idle");
    tick(3);

    // Overflow: one in flight, four buffered, one dropped
    send(ob[0]);
    tick(1);
    chk("ovf_start", 32'(uo_out[0]), 32'd0);
    fork
      begin
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        send(8'h66);
      end
    join_none
    for (int f = 0; f < 5; f++) begin
      capture(v, 10);
      chk($sformatf("ovf_frame%0d", f), 32'(v[9:0]), 32'({1'b1, ob[f], 1'b0}));
      if (f == 0) begin
        tick(1);
        chk("ovf_full", 32'(uo_out[2]), 32'd1);
        chk("ovf_flag", 32'(uo_out[4]), 32'd1);
        tick(1);
      end else begin
        tick(2);
      end
      if (f < 4) chk($sformatf("ovf_gap%0d", f), 32'(uo_out[0]), 32'd0);
    end
    expect_idle("ovf_only_five", 60);
    chk("ovf_sticky", 32'(uo_out[4]), 32'd1);

    // Asynchronous reset mid-frame
    send(8'hC3);
    tick(1);
    chk("rst_frame_start", 32'(uo_out[0]), 32'd0);
    tick(10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_uo_out", 32'(uo_out), 32'h09);
    chk("async_reset_uio_oe", 32'(uio_oe), 32'h00);
    chk("async_reset_uio_out", 32'(uio_out), 32'h00);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("rst_no_resume", 60);
    chk("rst_empty", 32'(uo_out[3]), 32'd1);

    // ena low: writes ignored, not counted as overflow
    ena = 1'b0;
    send(8'h12);
    send(8'h34);
    expect_idle("ena0_no_frame", 50);
    chk("ena0_no_ovf", 32'(uo_out[4]), 32'd0);
    chk("ena0_empty", 32'(uo_out[3]), 32'd1);

    // ena dropped mid-frame: frame completes, next byte waits
    ena = 1'b1;
    send(8'hC3);
    tick(1);
    chk("ena_mid_start", 32'(uo_out[0]), 32'd0);
    fork
      begin
        send(8'h5A);
        @(negedge clk);
        ena = 1'b0;
      end
    join_none
    capture(v, 10);
    chk("ena_mid_frame", 32'(v[9:0]), 32'(10'b1110000110));
    tick(2);
    chk("ena_hold_tx", 32'(uo_out[0]), 32'd1);
    chk("ena_hold_busy", 32'(uo_out[1]), 32'd1);
    chk("ena_hold_queued", 32'(uo_out[3]), 32'd0);
    expect_idle("ena_hold_idle", 20);
    ena = 1'b1;
    wait_start("ena_resume_start");
    capture(v, 10);
    chk("ena_resume_frame", 32'(v[9:0]), 32'(10'b1010110100));
    wait_not_busy("ena_resume_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
